// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register for the RISC-V core. It holds one
//               decoded instruction for EX and detects load-use hazards
//               against that held instruction. On a hazard it inserts one
//               bubble. A taken-branch flush discards the held instruction.
//               Every output is registered except stall_id.
// Ports       : clock, reset        - rising-edge clock, sync active-high reset
//               in_valid, in_*      - decoded instruction from ID
//               ex_ready            - EX consumes the held instruction
//               flush               - taken branch, kill held + incoming
//               stall_id            - combinational: ID/IF must hold
//               out_valid, out_*    - held instruction presented to EX
//               perf_*              - event counters, present only when
//                                     ID_EX_PERF_CNT_EN is defined
// Options     : ID_EX_PERF_CNT_EN   - adds perf_stall_cycles, perf_bubbles,
//                                     perf_flushes (32-bit, wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_readdata1,
    input  logic [XLEN-1:0] in_readdata2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [7:0]      in_ctrl,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            stall_id,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_readdata1,
    output logic [XLEN-1:0] out_readdata2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [7:0]      out_ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_flushes
`endif
);

    // Position of memread inside the control byte
    // {regwrite, memread, memwrite, memtoreg, alusrc, branch, aluop[1:0]}.
    localparam int C_MEMREAD_BIT = 6;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_readdata1;
    logic [XLEN-1:0] r_readdata2;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [7:0]      r_ctrl;

    logic w_hazard;
    logic w_hold;
    logic w_stall;
    logic w_bubble;

    // Load-use: the held instruction is a load whose destination (never x0)
    // is a source of the incoming instruction.
    assign w_hazard = in_valid & r_valid & r_ctrl[C_MEMREAD_BIT] &
                      (r_rd != 5'd0) & ((r_rd == in_rs1) | (r_rd == in_rs2));
    assign w_hold   = r_valid & ~ex_ready;
    assign w_stall  = ~flush & (w_hazard | w_hold);
    // Bubble is taken only when neither flush nor hold has priority.
    assign w_bubble = ~flush & ~w_hold & w_hazard;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_ctrl      <= 8'd0;
            r_pc        <= '0;
            r_readdata1 <= '0;
            r_readdata2 <= '0;
            r_imm       <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
        end else if (flush) begin
            // Data fields stay put; only validity and control are killed.
            r_valid <= 1'b0;
            r_ctrl  <= 8'd0;
        end else if (w_hold) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            // ID keeps the instruction and re-presents it after the bubble.
            r_valid <= 1'b0;
            r_ctrl  <= 8'd0;
        end else if (in_valid) begin
            r_valid     <= 1'b1;
            r_ctrl      <= in_ctrl;
            r_pc        <= in_pc;
            r_readdata1 <= in_readdata1;
            r_readdata2 <= in_readdata2;
            r_imm       <= in_imm;
            r_rs1       <= in_rs1;
            r_rs2       <= in_rs2;
            r_rd        <= in_rd;
        end else begin
            r_valid <= 1'b0;
            r_ctrl  <= 8'd0;
        end
    end

    assign stall_id      = w_stall;
    assign out_valid     = r_valid;
    assign out_ctrl      = r_ctrl;
    assign out_pc        = r_pc;
    assign out_readdata1 = r_readdata1;
    assign out_readdata2 = r_readdata2;
    assign out_imm       = r_imm;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_rd        = r_rd;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_flushes;

    // Counters wrap naturally at 32 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_stall_cycles <= 32'd0;
            r_perf_bubbles      <= 32'd0;
            r_perf_flushes      <= 32'd0;
        end else begin
            if (w_stall) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
            if (w_bubble) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
            if (flush) begin
                r_perf_flushes <= r_perf_flushes + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_bubbles      = r_perf_bubbles;
    assign perf_flushes      = r_perf_flushes;
`else
    // Bubble indication only feeds the counters.
    logic w_unused;
    assign w_unused = w_bubble;
`endif

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between the ID stage (register file read, immediate generation, control decode) and the EX stage of the RISC-V core. It captures one decoded instruction per cycle, detects load-use hazards against the instruction currently held for EX, and inserts a one-cycle bubble when one occurs. It also discards the held instruction on a taken-branch flush. All outputs are registered except the hazard/stall indication.

## Interface
- XLEN, 32, datapath width for pc, operands and immediate
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ID presents a decoded instruction
- in_pc  in  XLEN  instruction address
- in_readdata1, in_readdata2  in  XLEN  register file read values
- in_imm  in  XLEN  sign-extended immediate
- in_rs1, in_rs2, in_rd  in  5  register indices ([19:15], [24:20], [11:7])
- in_ctrl  in  8  {regwrite, memread, memwrite, memtoreg, alusrc, branch, aluop[1:0]}
- ex_ready  in  1  EX accepts the held instruction this cycle
- flush  in  1  taken branch resolved in EX; kill the held and incoming instruction
- stall_id  out  1  combinational; ID and IF must hold their state this cycle
- out_valid  out  1  held instruction is valid for EX
- out_pc, out_readdata1, out_readdata2, out_imm  out  XLEN  registered copies
- out_rs1, out_rs2, out_rd  out  5  registered copies
- out_ctrl  out  8  registered control; all zero whenever out_valid=0

## Operation
- hazard = in_valid & out_valid & out_ctrl.memread & (out_rd != 0) & (out_rd == in_rs1 | out_rd == in_rs2).
- hold = out_valid & ~ex_ready.
- stall_id = ~flush & (hazard | hold).
- Update priority at each rising clock edge:
  1. reset: out_valid=0; out_ctrl=0; all data and index outputs are 0.
  2. flush: out_valid=0, out_ctrl=0; data and index outputs keep their values; the incoming instruction is dropped.
  3. hold: all outputs unchanged.
  4. hazard: bubble, so out_valid=0 and out_ctrl=0; data outputs are unchanged. ID holds the instruction and re-presents it next cycle.
  5. in_valid: capture all in_* fields; out_valid=1; out_ctrl=in_ctrl.
  6. otherwise: out_valid=0, out_ctrl=0.
- Register x0 never triggers a hazard.
- A hazard always costs exactly one bubble. After the bubble, out_valid=0, so the hazard term clears and the re-presented instruction is captured.
- The block does no arithmetic; all fields pass through without modification.

## Timing
- Latency: 1 cycle from in_* sampled to out_* valid.
- Throughput: 1 instruction per cycle absent hazard, hold, or flush.
- stall_id is purely combinational from current inputs and registered state, with no registered delay.
- flush and hazard in the same cycle: flush wins, stall_id=0, and no bubble is counted.
- flush and hold in the same cycle: flush wins, and the held instruction is discarded regardless of ex_ready.
- reset asserted mid-stall: the next edge clears state, and stall_id deasserts as soon as out_valid=0.

## Configuration
- ID_EX_PERF_CNT_EN defined: adds three output ports, each a 32-bit counter.
  - perf_stall_cycles: increments every cycle stall_id=1.
  - perf_bubbles: increments on every hazard bubble insertion (priority 4 taken).
  - perf_flushes: increments on every edge where priority 2 is taken.
  - All three reset to 0 and wrap from 0xFFFFFFFF to 0.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Reset: drive in_valid=1 with garbage, assert reset for 2 cycles -> out_valid=0, out_ctrl=0, all outputs 0, stall_id=0.
- Streaming: 4 back-to-back independent instructions (pc 0x0,0x4,0x8,0xC), ex_ready=1 -> out_pc follows one cycle later each cycle, out_valid=1 continuously, stall_id=0.
- Load-use: held lw with rd=5, memread=1; next instruction has rs1=5 -> stall_id=1 for one cycle, then a bubble (out_valid=0, out_ctrl=0), then add captured on the following edge. Repeating with rd=0 gives no stall.
- Backpressure: out_valid=1, ex_ready=0 for 3 cycles -> outputs frozen, stall_id=1 for all 3 cycles. When ex_ready=1, the next instruction is captured.
- Flush: flush=1 while a hazard is present and ex_ready=0 -> stall_id=0 and out_valid=0 next cycle. Data outputs keep their values.
- Counters (ID_EX_PERF_CNT_EN): the load-use case followed by one flush -> perf_bubbles=1, perf_flushes=1, perf_stall_cycles=1. Preloading perf_stall_cycles to 0xFFFFFFFF via force, then stalling one cycle, wraps it to 0.
